// File: rtl/riscv_pkg.sv
// Shared definitions for the RV32 pipeline: data width, reset/bubble constants,
// the IF/ID register layout reused by the decode stage, and word-alignment helper.
package riscv_pkg;

    localparam int XLEN = 32;
    localparam logic [XLEN-1:0] NOP_INSTR        = 32'h0000_0013;
    localparam logic [XLEN-1:0] RESET_PC_DEFAULT = 32'h0000_0000;
    localparam logic [XLEN-1:0] WORD_MASK        = 32'hFFFF_FFFC;

    typedef struct packed {
        logic [XLEN-1:0] instr;
        logic [XLEN-1:0] pc;
        logic [XLEN-1:0] pc_plus4;
        logic            valid;
    } if_id_t;

    function automatic logic [XLEN-1:0] align_word(input logic [XLEN-1:0] addr);
        return addr & WORD_MASK;
    endfunction

endpackage

// File: rtl/pc_register.sv
// Program-counter flop: reset, redirect (overrides stall), stall hold, sequential
// increment. Redirect targets are forced to word alignment.
module pc_register
    import riscv_pkg::*;
#(
    parameter logic [XLEN-1:0] RESET_PC = RESET_PC_DEFAULT
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            stall,
    input  logic            redirect,
    input  logic [XLEN-1:0] target,
    output logic [XLEN-1:0] pc,
    output logic [XLEN-1:0] pc_plus4,
    output logic            target_misaligned
);

    logic [XLEN-1:0] pc_d;
    logic [XLEN-1:0] pc_q;

    // Next-PC selection and misalignment detection on the redirect target
    always_comb begin
        pc_plus4          = pc_q + 32'd4;
        target_misaligned = redirect && (target[1:0] != 2'b00);
        if (redirect) begin
            pc_d = align_word(target);
        end else if (stall) begin
            pc_d = pc_q;
        end else begin
            pc_d = pc_plus4;
        end
    end

    // PC state register
    always_ff @(posedge clk) begin
        if (rst) begin
            pc_q <= RESET_PC;
        end else begin
            pc_q <= pc_d;
        end
    end

    assign pc = pc_q;

endmodule

// File: rtl/fetch_stage.sv
// Instruction-fetch stage: PC (via pc_register), combinational imem address,
// IF/ID pipeline register, accepted-instruction counter and sticky misalign flag.
module fetch_stage
    import riscv_pkg::XLEN;
    import riscv_pkg::if_id_t;
    import riscv_pkg::RESET_PC_DEFAULT;
#(
    parameter logic [31:0] RESET_PC  = RESET_PC_DEFAULT,
    parameter logic [31:0] NOP_INSTR = riscv_pkg::NOP_INSTR
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        StallF,
    input  logic        StallD,
    input  logic        FlushD,
    input  logic        PCSrcE,
    input  logic [31:0] PCTargetE,
    output logic [31:0] imem_addr,
    input  logic [31:0] imem_rdata,
    output logic [31:0] PCF,
    output logic [31:0] InstrD,
    output logic [31:0] PCD,
    output logic [31:0] PCPlus4D,
    output logic        ValidD,
    output logic        misalign_err,
    output logic [31:0] fetch_count
);

    logic [XLEN-1:0] pc_f;
    logic [XLEN-1:0] pc_plus4_f;
    logic            target_misaligned;

    if_id_t          if_id_d;
    if_id_t          if_id_q;
    logic            misalign_err_d;
    logic            misalign_err_q;
    logic [31:0]     fetch_count_d;
    logic [31:0]     fetch_count_q;

    pc_register #(
        .RESET_PC (RESET_PC)
    ) u_pc_register (
        .clk               (clk),
        .rst               (rst),
        .stall             (StallF),
        .redirect          (PCSrcE),
        .target            (PCTargetE),
        .pc                (pc_f),
        .pc_plus4          (pc_plus4_f),
        .target_misaligned (target_misaligned)
    );

    // IF/ID next value, counter and sticky flag; flush beats stall
    always_comb begin
        if_id_d        = if_id_q;
        fetch_count_d  = fetch_count_q;
        misalign_err_d = misalign_err_q | target_misaligned;
        if (FlushD) begin
            if_id_d = '{instr: NOP_INSTR, pc: 32'd0, pc_plus4: 32'd0, valid: 1'b0};
        end else if (StallD) begin
            if_id_d = if_id_q;
        end else begin
            if_id_d       = '{instr: imem_rdata, pc: pc_f, pc_plus4: pc_plus4_f, valid: 1'b1};
            fetch_count_d = fetch_count_q + 32'd1;
        end
    end

    // IF/ID register, counter and flag state
    always_ff @(posedge clk) begin
        if (rst) begin
            if_id_q        <= '{instr: NOP_INSTR, pc: 32'd0, pc_plus4: 32'd0, valid: 1'b0};
            fetch_count_q  <= 32'd0;
            misalign_err_q <= 1'b0;
        end else begin
            if_id_q        <= if_id_d;
            fetch_count_q  <= fetch_count_d;
            misalign_err_q <= misalign_err_d;
        end
    end

    assign imem_addr    = pc_f;
    assign PCF          = pc_f;
    assign InstrD       = if_id_q.instr;
    assign PCD          = if_id_q.pc;
    assign PCPlus4D     = if_id_q.pc_plus4;
    assign ValidD       = if_id_q.valid;
    assign misalign_err = misalign_err_q;
    assign fetch_count  = fetch_count_q;

endmodule

// File: tb/tb_fetch_stage.sv
// Self-checking bench for fetch_stage: directed scenarios plus randomized
// stimulus against a cycle-level behavioural model of the fetch rules.
module tb_fetch_stage;

    logic        clk = 1'b0;
    always #5 clk = ~clk;

    logic        rst, StallF, StallD, FlushD, PCSrcE;
    logic [31:0] PCTargetE;
    logic [31:0] imem_addr, imem_rdata, PCF, InstrD, PCD, PCPlus4D, fetch_count;
    logic        ValidD, misalign_err;

    // Second instance with a PC near the top of the address space
    logic        rst2;
    logic [31:0] imem_addr2, imem_rdata2, PCF2, InstrD2, PCD2, PCPlus4D2, fetch_count2;
    logic        ValidD2, misalign_err2;

    assign imem_rdata  = imem_addr + 32'h100;
    assign imem_rdata2 = imem_addr2 + 32'h100;

    fetch_stage dut (
        .clk(clk), .rst(rst), .StallF(StallF), .StallD(StallD), .FlushD(FlushD),
        .PCSrcE(PCSrcE), .PCTargetE(PCTargetE), .imem_addr(imem_addr),
        .imem_rdata(imem_rdata), .PCF(PCF), .InstrD(InstrD), .PCD(PCD),
        .PCPlus4D(PCPlus4D), .ValidD(ValidD), .misalign_err(misalign_err),
        .fetch_count(fetch_count)
    );

    fetch_stage #(.RESET_PC(32'hFFFF_FFF8)) dut2 (
        .clk(clk), .rst(rst2), .StallF(1'b0), .StallD(1'b0), .FlushD(1'b0),
        .PCSrcE(1'b0), .PCTargetE(32'd0), .imem_addr(imem_addr2),
        .imem_rdata(imem_rdata2), .PCF(PCF2), .InstrD(InstrD2), .PCD(PCD2),
        .PCPlus4D(PCPlus4D2), .ValidD(ValidD2), .misalign_err(misalign_err2),
        .fetch_count(fetch_count2)
    );

    int n_checks = 0;
    int n_pass   = 0;

    // Behavioural model state
    logic [31:0] m_pc, m_instr, m_pcd, m_pcp4, m_cnt;
    logic        m_valid, m_err;

    task automatic drive(input logic r, input logic sf, input logic sd, input logic fd,
                         input logic ps, input logic [31:0] tgt);
        rst = r; StallF = sf; StallD = sd; FlushD = fd; PCSrcE = ps; PCTargetE = tgt;
    endtask

    // Advance one clock; the model applies the fetch rules to the pre-edge inputs
    task automatic tick();
        logic [31:0] n_pc, n_instr, n_pcd, n_pcp4, n_cnt;
        logic        n_valid, n_err;
        n_pc = m_pc; n_instr = m_instr; n_pcd = m_pcd; n_pcp4 = m_pcp4;
        n_cnt = m_cnt; n_valid = m_valid; n_err = m_err;
        if (rst) begin
            n_pc = 32'd0; n_instr = 32'h13; n_pcd = 32'd0; n_pcp4 = 32'd0;
            n_cnt = 32'd0; n_valid = 1'b0; n_err = 1'b0;
        end else begin
            if (PCSrcE)       n_pc = (PCTargetE / 32'd4) * 32'd4;
            else if (!StallF) n_pc = m_pc + 32'd4;
            if (PCSrcE && (PCTargetE % 32'd4) != 32'd0) n_err = 1'b1;
            if (FlushD) begin
                n_instr = 32'h13; n_pcd = 32'd0; n_pcp4 = 32'd0; n_valid = 1'b0;
            end else if (!StallD) begin
                n_instr = m_pc + 32'h100; n_pcd = m_pc; n_pcp4 = m_pc + 32'd4;
                n_valid = 1'b1; n_cnt = m_cnt + 32'd1;
            end
        end
        @(posedge clk);
        #1;
        m_pc = n_pc; m_instr = n_instr; m_pcd = n_pcd; m_pcp4 = n_pcp4;
        m_cnt = n_cnt; m_valid = n_valid; m_err = n_err;
    endtask

    task automatic test_reset();
        drive(1'b1, 1'b0, 1'b0, 1'b0, 1'b1, 32'h0000_0046);
        tick(); tick();
        n_checks++; if (PCF !== 32'd0) $display("FAIL reset_pcf got %h exp %h", PCF, 32'd0); else n_pass++;
        n_checks++; if (InstrD !== 32'h13) $display("FAIL reset_instr got %h exp %h", InstrD, 32'h13); else n_pass++;
        n_checks++; if (PCD !== 32'd0 || PCPlus4D !== 32'd0) $display("FAIL reset_pcd got %h/%h exp 0/0", PCD, PCPlus4D); else n_pass++;
        n_checks++; if (ValidD !== 1'b0 || misalign_err !== 1'b0) $display("FAIL reset_flags got %b/%b exp 0/0", ValidD, misalign_err); else n_pass++;
        n_checks++; if (fetch_count !== 32'd0) $display("FAIL reset_count got %0d exp 0", fetch_count); else n_pass++;
        n_checks++; if (imem_addr !== 32'd0) $display("FAIL reset_imem_addr got %h exp 0", imem_addr); else n_pass++;
    endtask

    task automatic test_free_run();
        drive(1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 32'd0);
        for (int i = 0; i < 4; i++) begin
            tick();
            n_checks++;
            if (PCD !== 32'(4 * i) || InstrD !== 32'(32'h100 + 4 * i) || ValidD !== 1'b1 || PCPlus4D !== 32'(4 * i + 4))
                $display("FAIL free_run_%0d got pcd=%h instr=%h pc4=%h v=%b exp pcd=%h instr=%h", i, PCD, InstrD, PCPlus4D, ValidD, 32'(4 * i), 32'(32'h100 + 4 * i));
            else n_pass++;
        end
        n_checks++; if (fetch_count !== 32'd4) $display("FAIL free_run_count got %0d exp 4", fetch_count); else n_pass++;
        n_checks++; if (PCF !== 32'h10) $display("FAIL free_run_pcf got %h exp 10", PCF); else n_pass++;
    endtask

    task automatic test_stall();
        drive(1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 32'd0);
        tick();
        drive(1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 32'd0);
        tick(); tick();
        drive(1'b0, 1'b1, 1'b1, 1'b0, 1'b0, 32'd0);
        for (int i = 0; i < 3; i++) begin
            tick();
            n_checks++;
            if (PCF !== 32'h8 || InstrD !== 32'h104 || PCD !== 32'h4 || fetch_count !== 32'd2)
                $display("FAIL stall_%0d got pcf=%h instr=%h pcd=%h cnt=%0d exp 8/104/4/2", i, PCF, InstrD, PCD, fetch_count);
            else n_pass++;
        end
        drive(1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 32'd0);
        tick();
        n_checks++; if (PCF !== 32'hC || PCD !== 32'h8) $display("FAIL stall_release got pcf=%h pcd=%h exp c/8", PCF, PCD); else n_pass++;
    endtask

    task automatic test_redirect_flush();
        logic [31:0] cnt_before;
        cnt_before = m_cnt;
        drive(1'b0, 1'b1, 1'b1, 1'b1, 1'b1, 32'h40);
        tick();
        n_checks++;
        if (PCF !== 32'h40 || InstrD !== 32'h13 || ValidD !== 1'b0 || fetch_count !== cnt_before)
            $display("FAIL redirect_flush got pcf=%h instr=%h v=%b cnt=%0d exp 40/13/0/%0d", PCF, InstrD, ValidD, fetch_count, cnt_before);
        else n_pass++;
        drive(1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 32'd0);
        tick();
        n_checks++;
        if (PCD !== 32'h40 || InstrD !== 32'h140 || ValidD !== 1'b1)
            $display("FAIL redirect_next got pcd=%h instr=%h v=%b exp 40/140/1", PCD, InstrD, ValidD);
        else n_pass++;
    endtask

    task automatic test_misalign();
        drive(1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 32'h46);
        tick();
        n_checks++; if (PCF !== 32'h44 || misalign_err !== 1'b1) $display("FAIL misalign_set got pcf=%h err=%b exp 44/1", PCF, misalign_err); else n_pass++;
        drive(1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 32'h80);
        tick();
        drive(1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 32'd0);
        tick();
        n_checks++; if (PCF !== 32'h84 || misalign_err !== 1'b1) $display("FAIL misalign_sticky got pcf=%h err=%b exp 84/1", PCF, misalign_err); else n_pass++;
        drive(1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 32'd0);
        tick();
        n_checks++; if (misalign_err !== 1'b0) $display("FAIL misalign_clear got %b exp 0", misalign_err); else n_pass++;
    endtask

    task automatic test_random();
        drive(1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 32'd0);
        for (int i = 0; i < 300; i++) begin
            drive(($urandom_range(0, 39) == 0), ($urandom_range(0, 3) == 0), ($urandom_range(0, 3) == 0),
                  ($urandom_range(0, 5) == 0), ($urandom_range(0, 7) == 0), $urandom);
            tick();
            n_checks++;
            if (PCF !== m_pc || imem_addr !== m_pc || InstrD !== m_instr || PCD !== m_pcd || PCPlus4D !== m_pcp4 ||
                ValidD !== m_valid || misalign_err !== m_err || fetch_count !== m_cnt)
                $display("FAIL random_%0d got pc=%h i=%h pcd=%h p4=%h v=%b e=%b c=%0d exp pc=%h i=%h pcd=%h p4=%h v=%b e=%b c=%0d",
                         i, PCF, InstrD, PCD, PCPlus4D, ValidD, misalign_err, fetch_count,
                         m_pc, m_instr, m_pcd, m_pcp4, m_valid, m_err, m_cnt);
            else n_pass++;
        end
    endtask

    task automatic test_mid_reset();
        drive(1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 32'h123);
        tick();
        drive(1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 32'd0);
        tick(); tick();
        drive(1'b1, 1'b1, 1'b1, 1'b1, 1'b1, 32'h55);
        tick();
        n_checks++;
        if (PCF !== 32'd0 || InstrD !== 32'h13 || PCD !== 32'd0 || PCPlus4D !== 32'd0 ||
            ValidD !== 1'b0 || misalign_err !== 1'b0 || fetch_count !== 32'd0)
            $display("FAIL mid_reset got pc=%h i=%h pcd=%h p4=%h v=%b e=%b c=%0d", PCF, InstrD, PCD, PCPlus4D, ValidD, misalign_err, fetch_count);
        else n_pass++;
    endtask

    task automatic test_wrap();
        n_checks++; if (PCF2 !== 32'hFFFF_FFF8) $display("FAIL wrap_reset got %h exp fffffff8", PCF2); else n_pass++;
        rst2 = 1'b0;
        @(posedge clk); #1;
        n_checks++; if (PCF2 !== 32'hFFFF_FFFC || PCD2 !== 32'hFFFF_FFF8) $display("FAIL wrap_1 got pcf=%h pcd=%h exp fffffffc/fffffff8", PCF2, PCD2); else n_pass++;
        @(posedge clk); #1;
        n_checks++; if (PCF2 !== 32'd0 || PCPlus4D2 !== 32'd0 || InstrD2 !== 32'h0000_00FC) $display("FAIL wrap_2 got pcf=%h pc4=%h instr=%h exp 0/0/fc", PCF2, PCPlus4D2, InstrD2); else n_pass++;
    endtask

    initial begin
        rst2 = 1'b1;
        m_pc = 32'd0; m_instr = 32'h13; m_pcd = 32'd0; m_pcp4 = 32'd0;
        m_cnt = 32'd0; m_valid = 1'b0; m_err = 1'b0;
        drive(1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 32'd0);
        #2;
        test_reset();
        test_free_run();
        test_stall();
        test_redirect_flush();
        test_misalign();
        test_random();
        test_mid_reset();
        test_wrap();
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule

// File: doc/fetch_stage.md
# fetch_stage

Instruction-fetch stage of the 32-bit RISC-V pipeline. It holds the program counter, drives the instruction-memory address, and registers the fetched instruction and PC into the IF/ID pipeline register. Its outputs `InstrD`, `PCD` and `PCPlus4D` feed the decode stage, which slices `InstrD` into `Op`, `funct3` and `funct7` for the control unit. Stall and flush come from the hazard unit; redirects come from the execute stage.

## Interface
Parameters:
- `RESET_PC`, 32'h0000_0000, PC value loaded on reset
- `NOP_INSTR`, 32'h0000_0013, bubble instruction (`addi x0,x0,0`) inserted on reset and flush

Ports:
- `clk`  in  1  single clock; all state updates on the rising edge
- `rst`  in  1  synchronous, active-high reset
- `StallF`  in  1  hold PC
- `StallD`  in  1  hold IF/ID register
- `FlushD`  in  1  replace IF/ID contents with a bubble
- `PCSrcE`  in  1  redirect request from execute (taken branch or jump)
- `PCTargetE`  in  32  redirect target
- `imem_addr`  out  32  instruction-memory address; combinational, equals `PCF`
- `imem_rdata`  in  32  instruction word; combinational read of `imem_addr`
- `PCF`  out  32  current fetch PC
- `InstrD`  out  32  IF/ID instruction
- `PCD`  out  32  IF/ID PC
- `PCPlus4D`  out  32  IF/ID PC+4
- `ValidD`  out  1  IF/ID holds a real instruction (0 = bubble)
- `misalign_err`  out  1  sticky flag: a redirect target had bits [1:0] != 0
- `fetch_count`  out  32  number of instructions accepted into IF/ID

## Operation
- `PCPlus4F = PCF + 4`, computed modulo 2^32. 32'hFFFF_FFFC wraps to 0.
- Next PC, in priority order:
  - `rst`: `RESET_PC`.
  - `PCSrcE`: `{PCTargetE[31:2],2'b00}`. A redirect overrides `StallF`.
  - `StallF`: hold.
  - Otherwise: `PCPlus4F`.
- IF/ID update, in priority order:
  - `rst` or `FlushD`: `InstrD=NOP_INSTR`, `PCD=0`, `PCPlus4D=0`, `ValidD=0`. A flush overrides `StallD`.
  - `StallD`: hold all four fields.
  - Otherwise: capture `imem_rdata`, `PCF`, `PCPlus4F`, and set `ValidD=1`.
- `misalign_err` sets when `PCSrcE=1` and `PCTargetE[1:0]!=0`. Only `rst` clears it. The redirect still happens, to the word-aligned address.
- `fetch_count` increments by 1, wrapping, on every capture in the "otherwise" case above. It does not increment on stall, flush or reset.
- Pipeline states per IF/ID slot: EMPTY (`ValidD=0`) and VALID. EMPTY→VALID on capture. VALID→EMPTY on flush. Stall holds the current state.

## Timing
- Reset values: `PCF=RESET_PC`, `InstrD=NOP_INSTR`, `PCD=0`, `PCPlus4D=0`, `ValidD=0`, `misalign_err=0`, `fetch_count=0`.
- The first valid instruction appears in IF/ID on the first edge after `rst` deasserts.
- Fetch-to-decode latency is 1 cycle. `imem_addr` follows `PCF` combinationally, with no registered memory latency.
- Redirect penalty: the PC loads the target on the edge where `PCSrcE=1`. The hazard unit asserts `FlushD` on that same edge to kill the wrong-path instruction.
- `StallF=1` with `StallD=1`: PC and IF/ID are both frozen and `fetch_count` is unchanged.
- `rst` asserted mid-operation takes effect on the next edge and overrides all other inputs.

## Structure
- Shared package `riscv_pkg` holds `XLEN=32`, `NOP_INSTR`, `RESET_PC_DEFAULT`, and an `if_id_t` struct of `{instr, pc, pc_plus4, valid}`. The decode-stage register reuses `if_id_t`.
- One sub-module: `pc_register`, which contains the PC flop with reset, redirect, stall priority and alignment masking.
- The IF/ID register, the counter and the sticky flag live at the top level.

## Test plan
- Reset, then free-run 4 cycles with `RESET_PC=0`, where the memory returns address+0x100 → `PCD` goes 0,4,8,C, `InstrD` goes 0x100,0x104,…, `ValidD=1` from cycle 1, and `fetch_count=4`.
- `StallF=StallD=1` for 3 cycles at `PCF=8` → `PCF`, `InstrD`, `PCD` and `fetch_count` are all unchanged. On release, `PCF` becomes C.
- `PCSrcE=1`, `PCTargetE=0x40`, `FlushD=1`, with `StallF=StallD=1` on the same edge → `PCF=0x40`, `InstrD=0x00000013`, `ValidD=0`, and the count is unchanged. Next edge: `PCD=0x40`.
- `PCSrcE=1`, `PCTargetE=0x46` → `PCF=0x44` and `misalign_err=1`. The flag stays 1 through later redirects and clears only on `rst`.
- `RESET_PC=32'hFFFF_FFF8`, free-run → `PCF` goes FFFF_FFF8, FFFF_FFFC, 0000_0000. Separately, assert `rst` mid-stream → all outputs return to their reset values on the next edge.
